// File: rtl/dip_pkg.sv
// Shared types and constants for the pixel pipeline: op-codes, controller
// states and the BT.601-style luma weights (which sum to 256).
package dip_pkg;

  typedef enum logic [2:0] {
    OP_BRIGHT_UP = 3'd0,
    OP_BRIGHT_DN = 3'd1,
    OP_GRAY      = 3'd2,
    OP_CH0_ONLY  = 3'd3,
    OP_CH1_ONLY  = 3'd4,
    OP_CH2_ONLY  = 3'd5,
    OP_THRESH    = 3'd6,
    OP_INVERT    = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int unsigned LUMA_W0 = 77;
  localparam int unsigned LUMA_W1 = 150;
  localparam int unsigned LUMA_W2 = 29;

endpackage

// File: rtl/dip_pixel_pipe_if.sv
// Pixel stream handshakes of the pipe: input stream in, processed stream out.
// The slave modport is the pipe's view, the master modport is the environment's.
interface dip_pixel_pipe_if #(
  parameter int W = 24
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/dip_pixel_alu.sv
// Combinational per-pixel operation; channel 0 sits in the most significant
// bits. The luma value arrives precomputed from the previous stage.
module dip_pixel_alu
  import dip_pkg::*;
#(
  parameter int CW  = 8,
  parameter int NCH = 3
) (
  input  op_e               op,
  input  logic [CW-1:0]     value,
  input  logic [NCH*CW-1:0] pix,
  input  logic [CW-1:0]     gray,
  output logic [NCH*CW-1:0] res
);
  localparam logic [CW-1:0] MAXV = '1;

  logic [CW-1:0] c;
  logic [CW-1:0] o;
  logic [CW:0]   sum;

  always_comb begin
    res = '0;
    c   = '0;
    o   = '0;
    sum = '0;
    for (int k = 0; k < NCH; k++) begin
      c   = pix[(NCH-1-k)*CW +: CW];
      sum = {1'b0, c} + {1'b0, value};
      case (op)
        OP_BRIGHT_UP: o = sum[CW] ? MAXV : sum[CW-1:0];
        OP_BRIGHT_DN: o = (c > value) ? (c - value) : '0;
        OP_GRAY:      o = gray;
        OP_CH0_ONLY:  o = (k == 0) ? c : '0;
        OP_CH1_ONLY:  o = (k == 1) ? c : '0;
        OP_CH2_ONLY:  o = (k == 2) ? c : '0;
        OP_THRESH:    o = (gray >= value) ? MAXV : '0;
        OP_INVERT:    o = MAXV - c;
        default:      o = '0;
      endcase
      res[(NCH-1-k)*CW +: CW] = o;
    end
  end
endmodule

// File: rtl/dip_pixel_pipe.sv
// Framed pixel processor: stage 1 captures the pixel and its luma, stage 2
// writes the operation result into an output FIFO; IDLE/RUN/DRAIN controller.
module dip_pixel_pipe
  import dip_pkg::*;
#(
  parameter int CW    = 8,
  parameter int NCH   = 3,
  parameter int DEPTH = 4,
  parameter int PCW   = 18
) (
  input  logic            clka,
  input  logic            reset_n,
  input  logic            start,
  input  logic            abort,
  input  logic [2:0]      op,
  input  logic [CW-1:0]   value,
  input  logic [PCW-1:0]  frame_len,
  dip_pixel_pipe_if.slave bus,
  output logic            busy,
  output logic            frame_done
);
  localparam int W   = NCH * CW;
  localparam int AW  = $clog2(DEPTH);
  localparam int CNW = AW + 1;

  state_e         state;
  op_e            op_q;
  logic [CW-1:0]  value_q;
  logic [PCW-1:0] len_q;
  logic [PCW-1:0] acc_cnt;
  logic           zlen_q;

  logic           s1_valid;
  logic           s1_last;
  logic [W-1:0]   s1_data;
  logic [CW-1:0]  s1_gray;
  logic [W-1:0]   alu_res;

  logic [W-1:0]   mem_data [DEPTH];
  logic           mem_last [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CNW-1:0] count;
  logic [CNW-1:0] occ;

  logic [CW-1:0]  ch [3];
  logic [CW+7:0]  luma;
  logic           accept;
  logic           pop;
  logic           head_last;
  logic           is_last_in;

  // Missing channels (NCH < 3) contribute zero to the luma sum.
  for (genvar k = 0; k < 3; k++) begin : g_ch
    if (k < NCH) begin : g_on
      assign ch[k] = bus.in_data[(NCH-1-k)*CW +: CW];
    end else begin : g_off
      assign ch[k] = '0;
    end
  end

  assign luma = (CW+8)'(LUMA_W0) * {8'd0, ch[0]}
              + (CW+8)'(LUMA_W1) * {8'd0, ch[1]}
              + (CW+8)'(LUMA_W2) * {8'd0, ch[2]};

  // Credit check counts the stage-1 pixel so the FIFO can never overflow.
  assign occ          = count + CNW'(s1_valid);
  assign bus.in_ready = (state == ST_RUN) && !abort && (occ < CNW'(DEPTH));
  assign accept       = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (count != '0);
  assign pop          = bus.out_valid && bus.out_ready;
  assign head_last    = mem_last[rd_ptr];
  assign bus.out_data = mem_data[rd_ptr];
  assign bus.out_last = bus.out_valid && head_last;
  assign is_last_in   = (acc_cnt == len_q - PCW'(1));
  assign busy         = (state != ST_IDLE);
  assign frame_done   = !abort && (zlen_q || ((state == ST_DRAIN) && pop && head_last));

  dip_pixel_alu #(.CW(CW), .NCH(NCH)) u_alu (
    .op    (op_q),
    .value (value_q),
    .pix   (s1_data),
    .gray  (s1_gray),
    .res   (alu_res)
  );

  always_ff @(posedge clka or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      op_q    <= OP_BRIGHT_UP;
      value_q <= '0;
      len_q   <= '0;
      acc_cnt <= '0;
      zlen_q  <= 1'b0;
    end else if (abort) begin
      state   <= ST_IDLE;
      acc_cnt <= '0;
      zlen_q  <= 1'b0;
    end else begin
      zlen_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q    <= op_e'(op);
            value_q <= value;
            len_q   <= frame_len;
            acc_cnt <= '0;
            if (frame_len == '0) begin
              zlen_q <= 1'b1;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (accept) begin
            acc_cnt <= acc_cnt + PCW'(1);
            if (is_last_in) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (pop && head_last) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clka or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_data  <= '0;
      s1_gray  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_last[i] <= 1'b0;
      end
    end else if (abort) begin
      s1_valid <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_data <= bus.in_data;
        s1_gray <= luma[CW+7:8];
        s1_last <= is_last_in;
      end
      if (s1_valid) begin
        mem_data[wr_ptr] <= alu_res;
        mem_last[wr_ptr] <= s1_last;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({s1_valid, pop})
        2'b10:   count <= count + CNW'(1);
        2'b01:   count <= count - CNW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_dip_pixel_pipe.sv
// Scoreboard bench for dip_pixel_pipe: stimulus pushes expected pixels from a
// reference model, an independent monitor pops them on each output transfer.
module tb_dip_pixel_pipe;
  import dip_pkg::*;

  typedef struct {
    logic [23:0] data;
    logic        last;
  } exp_t;

  logic        clka;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [2:0]  op;
  logic [7:0]  value;
  logic [17:0] frame_len;
  logic        busy;
  logic        frame_done;

  int compared   = 0;
  int mismatched = 0;
  int fdCount    = 0;
  int readyMode  = 0;

  exp_t        sb[$];
  logic [23:0] fixedPix[$];
  logic [23:0] fixedExp[$];

  dip_pixel_pipe_if #(.W(24)) bus ();

  dip_pixel_pipe #(.CW(8), .NCH(3), .DEPTH(4), .PCW(18)) dut (
    .clka       (clka),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .op         (op),
    .value      (value),
    .frame_len  (frame_len),
    .bus        (bus),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  // Reference: per-channel integer arithmetic straight from the operation rules.
  function automatic logic [23:0] refPixel(input int o, input int v, input logic [23:0] p);
    int c[3];
    int r[3];
    int g;
    c[0] = int'(p[23:16]);
    c[1] = int'(p[15:8]);
    c[2] = int'(p[7:0]);
    g = (77 * c[0] + 150 * c[1] + 29 * c[2]) / 256;
    for (int i = 0; i < 3; i++) begin
      case (o)
        0:       r[i] = (c[i] + v > 255) ? 255 : c[i] + v;
        1:       r[i] = (c[i] - v < 0) ? 0 : c[i] - v;
        2:       r[i] = g;
        3, 4, 5: r[i] = (i == o - 3) ? c[i] : 0;
        6:       r[i] = (g >= v) ? 255 : 0;
        default: r[i] = 255 - c[i];
      endcase
    end
    return {8'(r[0]), 8'(r[1]), 8'(r[2])};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int o, input int v, input int len, input int maxFeed,
                               input int gapPct, input bit midStart);
    int n = 0;
    int guard = 0;
    int lim;
    bit have = 0;
    logic [23:0] pix;
    logic [23:0] expd;
    exp_t e;
    lim = (maxFeed < len) ? maxFeed : len;
    @(posedge clka); #1;
    start = 1'b1; op = 3'(o); value = 8'(v); frame_len = 18'(len);
    @(posedge clka); #1;
    start = 1'b0;
    while (n < lim && guard < 4000) begin
      if (!have) begin
        if (fixedPix.size() > 0) pix = fixedPix.pop_front();
        else pix = 24'($urandom);
        if (fixedExp.size() > 0) expd = fixedExp.pop_front();
        else expd = refPixel(o, v, pix);
        have = 1;
      end
      bus.in_valid = ($urandom_range(0, 99) >= gapPct);
      bus.in_data  = pix;
      op           = 3'($urandom);
      value        = 8'($urandom);
      start        = midStart && (n == lim / 2);
      frame_len    = 18'($urandom_range(0, 3));
      @(negedge clka);
      if (bus.in_valid && bus.in_ready) begin
        e.data = expd;
        e.last = (n == len - 1);
        sb.push_back(e);
        n++;
        have = 0;
      end
      @(posedge clka); #1;
      guard++;
    end
    bus.in_valid = 1'b0;
    start        = 1'b0;
    checkOutput("feed_count", n, lim);
  endtask

  task automatic waitIdle(input int fdBase);
    int cyc = 0;
    do begin
      @(negedge clka);
      cyc++;
    end while ((sb.size() != 0 || busy) && cyc < 3000);
    checkOutput("frame_complete", 32'((sb.size() == 0) && !busy), 1);
    checkOutput("frame_done_count", fdCount - fdBase, 1);
  endtask

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clka); #1;
      case (readyMode)
        0:       bus.out_ready = 1'b1;
        2:       bus.out_ready = 1'b0;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compares every output transfer and the hold-while-stalled rule.
  initial begin
    bit          holdValid = 0;
    logic [31:0] holdData = '0;
    exp_t        e;
    forever begin
      @(negedge clka);
      if (!reset_n || abort) begin
        holdValid = 0;
        continue;
      end
      if (holdValid) begin
        checkOutput("hold_valid", 32'(bus.out_valid), 1);
        checkOutput("hold_data", {7'd0, bus.out_last, bus.out_data}, holdData);
      end
      holdValid = bus.out_valid && !bus.out_ready;
      holdData  = {7'd0, bus.out_last, bus.out_data};
      if (frame_done) fdCount++;
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_out: got 0x%0h, expected no output", bus.out_data);
        end else begin
          e = sb.pop_front();
          checkOutput("out_data", 32'(bus.out_data), 32'(e.data));
          checkOutput("out_last", 32'(bus.out_last), 32'(e.last));
          checkOutput("frame_done", 32'(frame_done), 32'(e.last));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int fdb;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; op = '0; value = '0; frame_len = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;

    @(negedge clka);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 0);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 0);
    checkOutput("rst_out_last", 32'(bus.out_last), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_frame_done", 32'(frame_done), 0);
    checkOutput("rst_out_data", 32'(bus.out_data), 0);
    @(posedge clka); #1;
    reset_n = 1'b1;

    $display("[TB] invert frame with latency check");
    readyMode = 0;
    fdb = fdCount;
    @(posedge clka); #1;
    start = 1'b1; op = 3'd7; value = '0; frame_len = 18'd3;
    @(posedge clka); #1;
    start = 1'b0; bus.in_valid = 1'b1; bus.in_data = 24'h102030;
    sb.push_back('{data: 24'hEFDFCF, last: 1'b0});
    @(negedge clka);
    checkOutput("inv_accept", 32'(bus.in_ready), 1);
    @(posedge clka); #1;
    bus.in_data = 24'hFFFFFF;
    sb.push_back('{data: 24'h000000, last: 1'b0});
    @(negedge clka);
    checkOutput("inv_lat1_valid", 32'(bus.out_valid), 0);
    @(posedge clka); #1;
    bus.in_data = 24'h000000;
    sb.push_back('{data: 24'hFFFFFF, last: 1'b1});
    @(negedge clka);
    checkOutput("inv_lat2_valid", 32'(bus.out_valid), 1);
    @(posedge clka); #1;
    bus.in_valid = 1'b0;
    waitIdle(fdb);

    $display("[TB] brightness and threshold corners");
    fdb = fdCount;
    fixedPix.push_back(24'hF8050A); fixedExp.push_back(24'hFF0F14);
    applyStimulus(0, 10, 1, 1, 0, 0);
    waitIdle(fdb);
    fdb = fdCount;
    fixedPix.push_back(24'h05FF0A); fixedExp.push_back(24'h00F500);
    applyStimulus(1, 10, 1, 1, 0, 0);
    waitIdle(fdb);
    fdb = fdCount;
    fixedPix.push_back(24'h808080); fixedExp.push_back(24'hFFFFFF);
    fixedPix.push_back(24'h7F7F7F); fixedExp.push_back(24'h000000);
    applyStimulus(6, 128, 2, 2, 0, 0);
    waitIdle(fdb);
    fdb = fdCount;
    fixedPix.push_back(24'h808080); fixedExp.push_back(24'h808080);
    applyStimulus(2, 0, 1, 1, 0, 0);
    waitIdle(fdb);

    $display("[TB] backpressure with output stalled");
    readyMode = 2;
    fdb = fdCount;
    fork
      applyStimulus(2, 0, 8, 8, 0, 0);
      begin
        repeat (10) @(negedge clka);
        checkOutput("stall_in_ready", 32'(bus.in_ready), 0);
        checkOutput("stall_inflight", sb.size(), 4);
        readyMode = 0;
      end
    join
    waitIdle(fdb);

    $display("[TB] randomized frames");
    readyMode = 1;
    for (int f = 0; f < 14; f++) begin
      int o, v, len, gap;
      bit mid;
      o   = $urandom_range(0, 7);
      v   = $urandom_range(0, 255);
      len = $urandom_range(1, 12);
      gap = $urandom_range(0, 50);
      mid = 1'($urandom_range(0, 1));
      fdb = fdCount;
      applyStimulus(o, v, len, len, gap, mid);
      waitIdle(fdb);
    end

    $display("[TB] abort mid-frame");
    readyMode = 0;
    fdb = fdCount;
    applyStimulus(7, 0, 5, 2, 0, 0);
    abort = 1'b1;
    sb.delete();
    @(posedge clka); #1;
    abort = 1'b0;
    @(negedge clka);
    checkOutput("abort_out_valid", 32'(bus.out_valid), 0);
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_frame_done", 32'(frame_done), 0);
    checkOutput("abort_no_done", fdCount - fdb, 0);
    fdb = fdCount;
    applyStimulus(6, 100, 1, 1, 0, 0);
    waitIdle(fdb);

    $display("[TB] reset during drain");
    readyMode = 2;
    fdb = fdCount;
    applyStimulus(7, 0, 3, 3, 0, 0);
    @(negedge clka);
    checkOutput("drain_busy", 32'(busy), 1);
    checkOutput("drain_out_valid", 32'(bus.out_valid), 1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("arst_out_valid", 32'(bus.out_valid), 0);
    checkOutput("arst_busy", 32'(busy), 0);
    checkOutput("arst_in_ready", 32'(bus.in_ready), 0);
    checkOutput("arst_out_last", 32'(bus.out_last), 0);
    checkOutput("arst_out_data", 32'(bus.out_data), 0);
    sb.delete();
    @(posedge clka);
    @(posedge clka); #1;
    reset_n = 1'b1;
    readyMode = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = 24'h123456;
    repeat (3) begin
      @(negedge clka);
      checkOutput("post_rst_in_ready", 32'(bus.in_ready), 0);
    end
    @(posedge clka); #1;
    bus.in_valid = 1'b0;
    checkOutput("rst_no_done", fdCount - fdb, 0);

    $display("[TB] zero-length frame");
    @(posedge clka); #1;
    start = 1'b1; op = 3'd0; frame_len = '0;
    @(posedge clka); #1;
    start = 1'b0;
    @(negedge clka);
    checkOutput("zlen_frame_done", 32'(frame_done), 1);
    checkOutput("zlen_busy", 32'(busy), 0);
    checkOutput("zlen_out_valid", 32'(bus.out_valid), 0);
    @(negedge clka);
    checkOutput("zlen_done_pulse", 32'(frame_done), 0);
    checkOutput("zlen_sb_empty", sb.size(), 0);

    repeat (3) @(posedge clka);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
